// File: rtl/idct_pkg.sv
// Shared types and constants for the 8-point distributed-arithmetic IDCT decoder.
package idct_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned ACCW = 36;
  localparam int unsigned FRAC = 14;

  typedef logic signed [15:0] rom_word_t;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StBfly,
    StOutput
  } state_e;

  // cos(pi/4) in Q2.14; the DC weight 0.5/sqrt2 is half of it.
  localparam rom_word_t C4  = 16'h2D41;
  localparam rom_word_t HC0 = (C4 + 16'sd1) >>> 1;
  // 0.5*cos(k*pi/16) in Q2.14
  localparam rom_word_t HC1 = 16'sd8035;
  localparam rom_word_t HC2 = 16'sd7568;
  localparam rom_word_t HC3 = 16'sd6811;
  localparam rom_word_t HC5 = 16'sd4551;
  localparam rom_word_t HC6 = 16'sd3135;
  localparam rom_word_t HC7 = 16'sd1598;

endpackage

// File: rtl/idct_da_rom.sv
// Combinational DA ROM: sum of the IDCT weights selected by a bit-plane address.
module idct_da_rom
  import idct_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic [3:0] addr_i,
  output rom_word_t  word_o
);

  rom_word_t w [4];

  always_comb begin
    w = '{default: '0};
    unique case (sel_i)
      3'd0: w = '{HC0,  HC2,  HC0,  HC6};
      3'd1: w = '{HC0,  HC6, -HC0, -HC2};
      3'd2: w = '{HC0, -HC6, -HC0,  HC2};
      3'd3: w = '{HC0, -HC2,  HC0, -HC6};
      3'd4: w = '{HC1,  HC3,  HC5,  HC7};
      3'd5: w = '{HC3, -HC7, -HC1, -HC5};
      3'd6: w = '{HC5, -HC1,  HC7,  HC3};
      3'd7: w = '{HC7, -HC5,  HC3, -HC1};
      default: w = '{default: '0};
    endcase
  end

  // addr_i[3] carries the lowest-frequency coefficient of the group.
  always_comb begin
    word_o = '0;
    for (int j = 0; j < 4; j++) begin
      if (addr_i[3-j]) word_o = word_o + w[j];
    end
  end

endmodule

// File: rtl/idct8_da_decoder.sv
// 8-point IDCT using bit-serial distributed arithmetic, one bit-plane per cycle.
module idct8_da_decoder #(
  parameter int unsigned DW   = idct_pkg::DW,
  parameter int unsigned ACCW = idct_pkg::ACCW,
  parameter int unsigned FRAC = idct_pkg::FRAC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] coef_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] sample_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);
  import idct_pkg::*;

  localparam int unsigned CW = $clog2(DW);
  localparam logic signed [ACCW-1:0] Half   = ACCW'(1) << (FRAC - 1);
  localparam logic signed [ACCW-1:0] SatMax = (ACCW'(1) << (DW - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] SatMin = ~SatMax;

  state_e                 state_q;
  logic [2:0]             idx_q, oidx_q;
  logic [CW-1:0]          cnt_q, plane;
  logic signed [DW-1:0]   x_q [8];
  logic signed [DW-1:0]   res_q [8];
  logic signed [DW-1:0]   res_d [8];
  logic signed [ACCW-1:0] acc_q [8];
  logic signed [ACCW-1:0] rom_ext [8];
  logic signed [ACCW-1:0] bf [8];
  logic signed [ACCW-1:0] rnd [8];
  rom_word_t              rom_w [8];
  logic [3:0]             even_addr, odd_addr;
  logic [DW-1:0]          sample_q;
  logic                   out_valid_q, out_last_q, in_ready_q;

  assign plane     = CW'(DW - 1) - cnt_q;
  assign even_addr = {x_q[0][plane], x_q[2][plane], x_q[4][plane], x_q[6][plane]};
  assign odd_addr  = {x_q[1][plane], x_q[3][plane], x_q[5][plane], x_q[7][plane]};

  // Instances 0..3 produce the even partial sums E0..E3, 4..7 the odd O0..O3.
  for (genvar i = 0; i < 8; i++) begin : g_rom
    idct_da_rom u_rom (
      .sel_i  (3'(i)),
      .addr_i ((i < 4) ? even_addr : odd_addr),
      .word_o (rom_w[i])
    );
    assign rom_ext[i] = {{(ACCW - 16){rom_w[i][15]}}, rom_w[i]};
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      bf[i]    = '0;
      rnd[i]   = '0;
      res_d[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      bf[i]     = acc_q[i] + acc_q[4+i];
      bf[7 - i] = acc_q[i] - acc_q[4+i];
    end
    for (int i = 0; i < 8; i++) begin
      rnd[i] = (bf[i] + Half) >>> FRAC;
      if (rnd[i] > SatMax)      res_d[i] = SatMax[DW-1:0];
      else if (rnd[i] < SatMin) res_d[i] = SatMin[DW-1:0];
      else                      res_d[i] = rnd[i][DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      idx_q       <= '0;
      oidx_q      <= '0;
      cnt_q       <= '0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        x_q[i]   <= '0;
        res_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StLoad: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            x_q[idx_q] <= coef_in;
            idx_q      <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q    <= StCompute;
              in_ready_q <= 1'b0;
              cnt_q      <= '0;
              for (int i = 0; i < 8; i++) acc_q[i] <= '0;
            end
          end
        end
        StCompute: begin
          // The first plane is the two's-complement sign plane, hence subtracted.
          for (int i = 0; i < 8; i++) begin
            acc_q[i] <= (cnt_q == '0) ? (acc_q[i] <<< 1) - rom_ext[i]
                                      : (acc_q[i] <<< 1) + rom_ext[i];
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) state_q <= StBfly;
        end
        StBfly: begin
          for (int i = 0; i < 8; i++) res_q[i] <= res_d[i];
          sample_q    <= res_d[0];
          oidx_q      <= '0;
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
          state_q     <= StOutput;
        end
        StOutput: begin
          if (out_ready) begin
            if (oidx_q == 3'd7) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              idx_q       <= '0;
              in_ready_q  <= 1'b1;
              state_q     <= StLoad;
            end else begin
              oidx_q     <= oidx_q + 3'd1;
              sample_q   <= res_q[oidx_q + 3'd1];
              out_last_q <= (oidx_q == 3'd6);
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign sample_out = sample_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;

endmodule

// File: tb/tb_idct8_da_decoder.sv
// Directed table-driven bench for idct8_da_decoder with a few hand-written corner sequences.
module tb_idct8_da_decoder;

  typedef struct packed {
    logic [7:0][15:0] x;
    logic [7:0][15:0] y;
    logic [7:0]       exact;  // bit i set: sample i checked exactly, else against real model
    logic [3:0]       gap;    // idle in_valid cycles inserted after beat 3
  } vec_t;

  localparam real Pi = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] coef_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] sample_out;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [15:0] got [8];
  logic               lst [8];
  vec_t               tbl [4];
  logic [7:0][15:0]   blk;
  int                 cyc;

  always #5 clk = ~clk;

  idct8_da_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coef_in    (coef_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic real ref_val(input logic [7:0][15:0] x, input int n);
    real s;
    real ck;
    s = 0.0;
    for (int k = 0; k < 8; k++) begin
      ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      s += 0.5 * ck * real'($signed(x[k])) * $cos(real'((2 * n + 1) * k) * Pi / 16.0);
    end
    return s;
  endfunction

  task automatic send_block(input logic [7:0][15:0] x, input int gap);
    int guard;
    for (int i = 0; i < 8; i++) begin
      coef_in  = x[i];
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      if (i == 3 && gap > 0) begin
        in_valid = 1'b0;
        coef_in  = 16'hDEAD;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
  endtask

  // Counts the cycle index (relative to the 8th beat's cycle) at which out_valid first rises.
  task automatic wait_out(input bit junk, output int c);
    c = 1;
    while (!out_valid && c < 60) begin
      if (junk) begin
        in_valid = 1'b1;
        coef_in  = 16'h8000;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic recv_block(input int stall_idx);
    logic [15:0] hold;
    int guard;
    for (int i = 0; i < 8; i++) begin
      guard = 0;
      while (!out_valid && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!out_valid) begin
        check("recv_timeout", 0, 1);
        return;
      end
      if (i == stall_idx) begin
        out_ready = 1'b0;
        hold = sample_out;
        repeat (3) begin
          @(posedge clk); #1;
          check("stall_stable", sample_out, hold);
          check("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
      end
      got[i] = sample_out;
      lst[i] = out_last;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    coef_in   = '0;
    out_ready = 1'b1;

    tbl[0] = '{x: '0, y: '0, exact: 8'hFF, gap: 4'd0};
    tbl[1] = '{x: '0, y: '0, exact: 8'hFF, gap: 4'd0};
    tbl[1].x[0] = 16'd800;
    for (int i = 0; i < 8; i++) tbl[1].y[i] = 16'd283;
    tbl[2] = '{x: '0, y: '0, exact: 8'hFF, gap: 4'd5};
    tbl[2].x[4] = 16'd1000;
    tbl[2].y = {16'd354, -16'sd354, -16'sd354, 16'd354, 16'd354, -16'sd354, -16'sd354, 16'd354};
    tbl[3] = '{x: '0, y: '0, exact: 8'h81, gap: 4'd0};
    tbl[3].x[1] = 16'd1000;
    tbl[3].y[0] = 16'd490;
    tbl[3].y[7] = -16'sd490;

    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sample", sample_out, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    for (int t = 0; t < 4; t++) begin
      send_block(tbl[t].x, int'(tbl[t].gap));
      check("busy_in_ready", in_ready, 0);
      wait_out(1'b0, cyc);
      check($sformatf("v%0d_latency", t), cyc, 18);
      recv_block(-1);
      for (int i = 0; i < 8; i++) begin
        if (tbl[t].exact[i]) begin
          check($sformatf("v%0d_x%0d", t, i), got[i], $signed(tbl[t].y[i]));
        end else begin
          real d;
          d = real'(got[i]) - ref_val(tbl[t].x, i);
          n_checks++;
          if (d > 1.0 || d < -1.0) begin
            n_fail++;
            $display("FAIL v%0d_x%0d_model: got %0d, expected %f +/-1", t, i, got[i],
                     ref_val(tbl[t].x, i));
          end
        end
        check($sformatf("v%0d_last%0d", t, i), lst[i], (i == 7) ? 1 : 0);
      end
      check("in_ready_after_block", in_ready, 1);
    end

    // Full-scale block: saturation, output stall on x2, in_valid ignored while busy.
    for (int i = 0; i < 8; i++) blk[i] = 16'h7FFF;
    send_block(blk, 0);
    wait_out(1'b1, cyc);
    check("sat_latency", cyc, 18);
    recv_block(2);
    check("sat_x0", got[0], 32767);
    check("sat_x2", got[2], 18715);
    check("sat_x7", got[7], 2588);
    check("sat_last7", lst[7], 1);

    // Reset during COMPUTE cycle 7 discards the block.
    send_block(blk, 0);
    repeat (6) begin @(posedge clk); #1; end
    check("mid_compute_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_sample", sample_out, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_sample", sample_out, 0);
    blk = '0;
    blk[0] = 16'd800;
    send_block(blk, 0);
    wait_out(1'b0, cyc);
    check("post_rst_latency", cyc, 18);
    recv_block(-1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("post_rst_x%0d", i), got[i], 283);
      check($sformatf("post_rst_last%0d", i), lst[i], (i == 7) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
